// File: rtl/crc_pkg.sv
// Shared types and constants for the bit-serial CRC-8 frame sequencer.
package crc_pkg;
    localparam int DATA_W     = 8;
    localparam int CRC_WIDTH  = 8;
    localparam int CNT_W      = $clog2(DATA_W);
    localparam logic [CRC_WIDTH-1:0] DEF_POLY = 8'h07;
    localparam logic [CRC_WIDTH-1:0] DEF_SEED = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        OUT   = 2'd3
    } state_e;
endpackage

// File: rtl/crc8_lfsr.sv
// MSB-first serial CRC LFSR: init loads SEED, en absorbs one bit per clock.
module crc8_lfsr
    import crc_pkg::*;
#(
    parameter logic [CRC_WIDTH-1:0] POLY = DEF_POLY,
    parameter logic [CRC_WIDTH-1:0] SEED = DEF_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] lfsr_q
);
    logic                 fb;
    logic [CRC_WIDTH-1:0] lfsr_d;

    always_comb begin
        fb     = lfsr_q[CRC_WIDTH-1] ^ bit_in;
        lfsr_d = lfsr_q;
        if (init) begin
            lfsr_d = SEED;
        end else if (en) begin
            lfsr_d = {lfsr_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
endmodule

// File: rtl/crc_frame_ctrl.sv
// Byte-to-serial CRC-8 frame sequencer; CRC_PARALLEL_OUT_EN adds a parallel
// crc_byte/crc_byte_valid result port alongside the serial output.
module crc_frame_ctrl
    import crc_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = crc_pkg::CRC_WIDTH,
    parameter logic [CRC_WIDTH-1:0] POLY       = DEF_POLY,
    parameter logic [CRC_WIDTH-1:0] SEED       = DEF_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  CRC,
    output logic                  valid,
    output logic                  done_tick,
`ifdef CRC_PARALLEL_OUT_EN
    output logic [CRC_WIDTH-1:0]  crc_byte,
    output logic                  crc_byte_valid,
`endif
    output logic                  busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   byte_q, byte_d;
    logic                    last_q, last_d;
    logic                    crc_q, crc_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    accept;
    logic                    lfsr_init, lfsr_en;
    logic [CRC_WIDTH-1:0]    lfsr_q;

    crc8_lfsr #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .init   (lfsr_init),
        .en     (lfsr_en),
        .bit_in (byte_q[~bit_cnt_q]),
        .lfsr_q (lfsr_q)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        last_d    = last_q;
        lfsr_init = 1'b0;
        lfsr_en   = 1'b0;
        in_ready  = (state_q == IDLE) || (state_q == GAP);
        busy      = (state_q != IDLE);
        accept    = in_valid & in_ready;

        case (state_q)
            IDLE, GAP: begin
                if (accept) begin
                    lfsr_init = (state_q == IDLE);
                    byte_d    = in_data;
                    last_d    = in_last;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_en   = 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_MAX) begin
                    state_d = last_q ? OUT : GAP;
                end
            end
            OUT: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Serial outputs trail the OUT state by one register stage; done fires
        // the cycle after the final valid bit.
        valid_d = (state_q == OUT);
        crc_d   = (state_q == OUT) ? lfsr_q[~bit_cnt_q] : 1'b0;
        done_d  = valid_q && (state_q != OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            crc_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            crc_q     <= crc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign CRC       = crc_q;
    assign valid     = valid_q;
    assign done_tick = done_q;

`ifdef CRC_PARALLEL_OUT_EN
    logic [CRC_WIDTH-1:0] crc_byte_q;
    logic                 crc_byte_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_byte_q       <= '0;
            crc_byte_valid_q <= 1'b0;
        end else begin
            crc_byte_valid_q <= (state_q == OUT) && (bit_cnt_q == '0);
            if ((state_q == OUT) && (bit_cnt_q == '0)) begin
                crc_byte_q <= lfsr_q;
            end
        end
    end

    assign crc_byte       = crc_byte_q;
    assign crc_byte_valid = crc_byte_valid_q;
`endif
endmodule
